// File: rtl/wb_cmd_pkg.sv
// Shared types for the Wishbone command master.
// FSM encoding and default abort threshold.
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam int TIMEOUT_DEF = 255;
    localparam int TO_W_DEF    = 8;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command/response streams plus Wishbone classic bus.
// master = initiator side, slave = command source, sink and WB target.
interface wb_cmd_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [DW/8-1:0]   cmd_sel;
    logic [AW-1:0]     cmd_adr;
    logic [DW-1:0]     cmd_dat;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_dat;
    logic              rsp_err;

    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [DW/8-1:0]   wbm_sel_o;
    logic [AW-1:0]     wbm_adr_o;
    logic [DW-1:0]     wbm_dat_o;
    logic [DW-1:0]     wbm_dat_i;
    logic              wbm_ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err,
        input  rsp_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o,
        output wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err,
        output rsp_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
        input  wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/wb_cmd_master.sv
// Single-beat Wishbone classic initiator fed by a command stream.
// One transaction in flight; read data or timeout error returned.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_cmd_master_if.master bus,
    output logic            busy_o
);

    localparam int SW = DW / 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state, state_n;
    logic [TO_W-1:0] cnt, cnt_n;
    logic [DW-1:0]   rsp_dat_n;
    logic            rsp_err_n;
    logic            load;

    logic            cmd_ready_q;
    logic            rsp_valid_q;
    logic [DW-1:0]   rsp_dat_q;
    logic            rsp_err_q;
    logic            cyc_q;
    logic            busy_q;
    logic            we_q;
    logic [SW-1:0]   sel_q;
    logic [AW-1:0]   adr_q;
    logic [DW-1:0]   dat_q;

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_n;
    end

    // Next state, timeout count and response capture; ack beats timeout.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rsp_dat_n = rsp_dat_q;
        rsp_err_n = rsp_err_q;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_n = REQ;
                    cnt_n   = '0;
                    load    = 1'b1;
                end
            end
            REQ: begin
                if (bus.wbm_ack_i) begin
                    state_n   = RSP;
                    rsp_dat_n = we_q ? '0 : bus.wbm_dat_i;
                    rsp_err_n = 1'b0;
                end else if (cnt == TO_LAST) begin
                    state_n   = RSP;
                    rsp_dat_n = '0;
                    rsp_err_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RSP: begin
                if (bus.rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output and datapath registers, all decoded from the next state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt         <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cyc_q       <= 1'b0;
            busy_q      <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
        end else begin
            cnt         <= cnt_n;
            cmd_ready_q <= (state_n == IDLE);
            rsp_valid_q <= (state_n == RSP);
            rsp_dat_q   <= rsp_dat_n;
            rsp_err_q   <= rsp_err_n;
            cyc_q       <= (state_n == REQ);
            busy_q      <= (state_n != IDLE);
            if (load) begin
                we_q  <= bus.cmd_we;
                sel_q <= bus.cmd_sel;
                adr_q <= bus.cmd_adr;
                dat_q <= bus.cmd_dat;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign busy_o        = busy_q;

endmodule
